// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage access unit.
// Size encodings, exception codes, the in-flight metadata entry, and the
// store-lane replication / load alignment-extension functions.
package mem_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_e;

    localparam logic [3:0] EXC_NONE = 4'd0;
    localparam logic [3:0] EXC_ADEL = 4'd4;
    localparam logic [3:0] EXC_ADES = 4'd5;

    // One entry per accepted-but-unanswered bus request.
    typedef struct packed {
        logic      wr;
        mem_size_e size;
        logic      sgn;
        logic [1:0] addr_lo;
        logic      discard;
    } mem_meta_t;

    // Replicate right-aligned store data across all byte lanes.
    function automatic logic [31:0] mem_replicate_wdata(input mem_size_e size,
                                                        input logic [31:0] wdata);
        logic [31:0] r;
        case (size)
            BYTE:    r = {4{wdata[7:0]}};
            HALF:    r = {2{wdata[15:0]}};
            default: r = wdata;
        endcase
        return r;
    endfunction

    // Shift the returned word down to its lane, then zero/sign-extend.
    function automatic logic [31:0] mem_extend_load(input logic [31:0] rdata,
                                                    input logic [1:0]  addr_lo,
                                                    input mem_size_e   size,
                                                    input logic        sgn);
        logic [31:0] sh;
        logic [31:0] r;
        sh = rdata >> {addr_lo, 3'b000};
        case (size)
            BYTE:    r = {{24{sgn & sh[7]}}, sh[7:0]};
            HALF:    r = {{16{sgn & sh[15]}}, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_pending_fifo.sv
// In-order FIFO of in-flight request metadata.
// Supports push, pop, occupancy count and a one-shot mark-all-discard; an entry
// pushed in the same cycle as a discard mark keeps its own (clear) discard bit.
module mem_pending_fifo
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  mem_meta_t        i_push_data,
    input  logic             i_pop,
    input  logic             i_mark_discard,
    output mem_meta_t        o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    mem_meta_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;

    // Explicit wrap keeps the pointers legal for any depth, including 1.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Occupancy after this cycle's push/pop.
    always_comb begin
        w_count_next = r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end

    // Entry storage: discard marking first, so a same-cycle push overrides it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_mark_discard) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    r_mem[i].discard <= 1'b1;
                end
            end
            if (i_push) begin
                r_mem[r_wptr] <= i_push_data;
            end
        end
    end

    // Read/write pointers and occupancy count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= ptr_inc(r_wptr);
            if (i_pop)  r_rptr <= ptr_inc(r_rptr);
            r_count <= w_count_next;
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/mem_access_unit.sv
// Pipelined MEM-stage load/store unit with multiple outstanding bus requests.
// Optional feature macro: MEM_ALIGN_EXC_EN -- when defined, misaligned half/word
// accesses raise ADEL/ADES and skip the bus; otherwise addresses are force-aligned.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic             op_wr,
    input  logic [1:0]       op_size,
    input  logic             op_signed,
    input  logic             op_kill,
    input  logic [31:0]      op_addr,
    input  logic [31:0]      op_wdata,
    output logic [3:0]       op_exc,
    input  logic             flush,
    output logic             resp_valid,
    output logic             resp_is_load,
    output logic [31:0]      resp_data,
    output logic             data_req,
    output logic             data_wr,
    output logic [1:0]       data_size,
    output logic [31:0]      data_addr,
    output logic [31:0]      data_wdata,
    input  logic [31:0]      data_rdata,
    input  logic             data_addr_ok,
    input  logic             data_data_ok,
    output logic [CNT_W-1:0] pending,
    output logic             stall
);

    logic [3:0]       w_exc;
    logic [31:0]      w_addr_aligned;
    logic             w_issue;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_head_discard;
    logic [CNT_W-1:0] w_cnt_next;
    mem_meta_t        w_push_data;
    mem_meta_t        w_head;

    logic             r_draining;
    logic             r_resp_valid;
    logic             r_resp_is_load;
    logic [31:0]      r_resp_data;

    // Alignment exception for the presented op.
`ifdef MEM_ALIGN_EXC_EN
    logic w_misaligned;
    always_comb begin
        w_misaligned = 1'b0;
        case (op_size)
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = op_addr[0];
            default: w_misaligned = |op_addr[1:0];
        endcase
        w_exc = EXC_NONE;
        if (op_valid && w_misaligned) begin
            w_exc = op_wr ? EXC_ADES : EXC_ADEL;
        end
    end
`else
    assign w_exc = EXC_NONE;
`endif

    // Force natural alignment on the bus address; a no-op for ops that issue
    // when alignment exceptions are enabled.
    always_comb begin
        w_addr_aligned = op_addr;
        case (op_size)
            2'b00:   w_addr_aligned = op_addr;
            2'b01:   w_addr_aligned[0] = 1'b0;
            default: w_addr_aligned[1:0] = 2'b00;
        endcase
    end

    // Issue, consume and FIFO push/pop decisions.
    always_comb begin
        w_issue  = op_valid & ~op_kill & (w_exc == EXC_NONE) & ~w_full & ~r_draining;
        w_push   = w_issue & data_addr_ok;
        // A pop with nothing in flight is a bus protocol error; ignore it.
        w_pop    = data_data_ok & (pending != '0);
        op_ready = op_valid & (op_kill | (w_exc != EXC_NONE) | w_push);
        stall    = op_valid & ~op_ready;

        w_push_data = '{
            wr:      op_wr,
            size:    mem_size_e'(op_size),
            sgn:     op_signed,
            addr_lo: w_addr_aligned[1:0],
            discard: 1'b0
        };

        w_cnt_next     = pending + CNT_W'(w_push) - CNT_W'(w_pop);
        // A flush also swallows the entry popping in the same cycle.
        w_head_discard = w_head.discard | flush;
    end

    assign op_exc     = w_exc;
    assign data_req   = w_issue;
    assign data_wr    = op_wr;
    assign data_size  = op_size;
    assign data_addr  = w_addr_aligned;
    assign data_wdata = mem_replicate_wdata(mem_size_e'(op_size), op_wdata);

    mem_pending_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_pending_fifo (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_push         (w_push),
        .i_push_data    (w_push_data),
        .i_pop          (w_pop),
        .i_mark_discard (flush),
        .o_head         (w_head),
        .o_count        (pending),
        .o_full         (w_full)
    );

    // Drain state: set by flush, held until nothing remains in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_draining <= 1'b0;
        end else begin
            r_draining <= (r_draining | flush) & (w_cnt_next != '0);
        end
    end

    // Registered response; data is held until the next delivered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_valid   <= 1'b0;
            r_resp_is_load <= 1'b0;
            r_resp_data    <= '0;
        end else begin
            r_resp_valid <= w_pop & ~w_head_discard;
            if (w_pop && !w_head_discard) begin
                r_resp_is_load <= ~w_head.wr;
                r_resp_data    <= w_head.wr ? '0 :
                    mem_extend_load(data_rdata, w_head.addr_lo, w_head.size, w_head.sgn);
            end
        end
    end

    assign resp_valid   = r_resp_valid;
    assign resp_is_load = r_resp_is_load;
    assign resp_data    = r_resp_data;

    // Bus must never answer when nothing is outstanding.
    a_no_spurious_data_ok: assert property (
        @(posedge clk) disable iff (rst) data_data_ok |-> (pending != '0)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a response scoreboard.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid, op_ready, op_wr, op_signed, op_kill;
    logic [1:0]  op_size;
    logic [31:0] op_addr, op_wdata;
    logic [3:0]  op_exc;
    logic        flush;
    logic        resp_valid, resp_is_load;
    logic [31:0] resp_data;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic [1:0]  pending;
    logic        stall;

    typedef struct {
        logic        is_load;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_access_unit #(
        .MAX_OUTSTANDING (2),
        .CNT_W           (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_wr        (op_wr),
        .op_size      (op_size),
        .op_signed    (op_signed),
        .op_kill      (op_kill),
        .op_addr      (op_addr),
        .op_wdata     (op_wdata),
        .op_exc       (op_exc),
        .flush        (flush),
        .resp_valid   (resp_valid),
        .resp_is_load (resp_is_load),
        .resp_data    (resp_data),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .pending      (pending),
        .stall        (stall)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_op(input logic wr, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata);
        op_valid  = 1'b1;
        op_wr     = wr;
        op_size   = size;
        op_signed = sgn;
        op_addr   = addr;
        op_wdata  = wdata;
        op_kill   = 1'b0;
    endtask

    task automatic expect_resp(input logic is_load, input logic [31:0] data);
        exp_t e;
        e.is_load = is_load;
        e.data    = data;
        exp_q.push_back(e);
    endtask

    // Returned word for the wrap test: marker byte in the op's lane, filler elsewhere.
    function automatic logic [31:0] lane_word(input int j);
        logic [31:0] w;
        w = 32'h5A5A_5A5A;
        w[8*(j%4) +: 8] = 8'hA0 + 8'(j);
        return w;
    endfunction

    // Monitor: every delivered response must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp: got data 0x%08h expected no response at %0t",
                         resp_data, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_is_load", 32'(resp_is_load), 32'(e.is_load));
                check("resp_data", resp_data, e.data);
            end
        end
    end

    initial begin
        rst = 1'b1; op_valid = 0; op_wr = 0; op_size = 0; op_signed = 0; op_kill = 0;
        op_addr = 0; op_wdata = 0; flush = 0; data_rdata = 0; data_addr_ok = 0;
        data_data_ok = 0;
        repeat (2) @(negedge clk);
        check("rst_pending", 32'(pending), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_data_req", 32'(data_req), 0);
        check("rst_stall", 32'(stall), 0);
        rst = 1'b0;

        // Signed byte load from the top lane.
        @(negedge clk);
        set_op(0, 2'b00, 1, 32'h1003, 0); data_addr_ok = 1;
        #1;
        check("lb_req", 32'(data_req), 1);
        check("lb_addr", data_addr, 32'h1003);
        check("lb_size", 32'(data_size), 0);
        check("lb_ready", 32'(op_ready), 1);
        @(negedge clk);
        op_valid = 0; data_addr_ok = 0;
        check("lb_pending", 32'(pending), 1);
        data_data_ok = 1; data_rdata = 32'h80FF_FF7F; expect_resp(1, 32'hFFFF_FF80);
        @(negedge clk);
        data_data_ok = 0;
        check("lb_pending_done", 32'(pending), 0);
        @(negedge clk);
        check("lb_valid_pulse", 32'(resp_valid), 0);
        check("lb_data_held", resp_data, 32'hFFFF_FF80);

        // Store half: replicated lanes.
        @(negedge clk);
        set_op(1, 2'b01, 0, 32'h2002, 32'h0000_BEEF); data_addr_ok = 1;
        #1;
        check("sh_wdata", data_wdata, 32'hBEEF_BEEF);
        check("sh_size", 32'(data_size), 1);
        check("sh_addr", data_addr, 32'h2002);
        check("sh_wr", 32'(data_wr), 1);
        @(negedge clk);
        op_valid = 0; data_addr_ok = 0;
        data_data_ok = 1; data_rdata = 32'h1234_5678; expect_resp(0, 0);
        @(negedge clk);
        data_data_ok = 0;

        // Back-to-back loads, third stalls on a full FIFO.
        @(negedge clk);
        set_op(0, 2'b10, 0, 32'h100, 0); data_addr_ok = 1;
        @(negedge clk);
        set_op(0, 2'b10, 0, 32'h104, 0);
        #1 check("b2b_ready2", 32'(op_ready), 1);
        @(negedge clk);
        set_op(0, 2'b01, 1, 32'h10A, 0);
        #1;
        check("b2b_pending_full", 32'(pending), 2);
        check("b2b_req_blocked", 32'(data_req), 0);
        check("b2b_stall", 32'(stall), 1);
        @(negedge clk);
        data_data_ok = 1; data_rdata = 32'h11; expect_resp(1, 32'h11);
        #1 check("b2b_no_ready_through_pop", 32'(op_ready), 0);
        @(negedge clk);
        data_data_ok = 0;
        #1;
        check("b2b_pending_after_pop", 32'(pending), 1);
        check("b2b_ready3", 32'(op_ready), 1);
        @(negedge clk);
        op_valid = 0; data_addr_ok = 0;
        check("b2b_pending_refill", 32'(pending), 2);
        data_data_ok = 1; data_rdata = 32'h22; expect_resp(1, 32'h22);
        @(negedge clk);
        data_rdata = 32'hF00D_0000; expect_resp(1, 32'hFFFF_F00D);
        @(negedge clk);
        data_data_ok = 0;
        check("b2b_drained", 32'(pending), 0);

        // Push and pop every cycle over 11 ops; pointers wrap repeatedly.
        @(negedge clk);
        set_op(0, 2'b00, 0, 32'h400, 0); data_addr_ok = 1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            set_op(0, 2'b00, 0, 32'h400 + 32'(i), 0);
            data_data_ok = 1; data_rdata = lane_word(i - 1);
            expect_resp(1, 32'(8'hA0 + 8'(i - 1)));
            #1;
            check("wrap_pending", 32'(pending), 1);
            check("wrap_ready", 32'(op_ready), 1);
        end
        @(negedge clk);
        op_valid = 0; data_addr_ok = 0;
        data_rdata = lane_word(10); expect_resp(1, 32'hAA);
        @(negedge clk);
        data_data_ok = 0;
        check("wrap_drained", 32'(pending), 0);

        // Flush with two loads pending, coincident with the first return.
        @(negedge clk);
        set_op(0, 2'b10, 0, 32'h500, 0); data_addr_ok = 1;
        @(negedge clk);
        set_op(0, 2'b10, 0, 32'h504, 0);
        @(negedge clk);
        op_valid = 0; data_addr_ok = 0;
        flush = 1; data_data_ok = 1; data_rdata = 32'hDEAD_0001;
        @(negedge clk);
        flush = 0; data_data_ok = 0;
        set_op(0, 2'b10, 0, 32'h508, 0); data_addr_ok = 1;
        #1;
        check("flush_pending", 32'(pending), 1);
        check("flush_req_blocked", 32'(data_req), 0);
        check("flush_stall", 32'(stall), 1);
        @(negedge clk);
        data_data_ok = 1; data_rdata = 32'hDEAD_0002;
        #1 check("flush_still_draining", 32'(data_req), 0);
        @(negedge clk);
        data_data_ok = 0;
        #1;
        check("flush_pending_zero", 32'(pending), 0);
        check("flush_issue_resumes", 32'(data_req), 1);
        check("flush_ready", 32'(op_ready), 1);
        @(negedge clk);
        op_valid = 0; data_addr_ok = 0;
        check("flush_new_pending", 32'(pending), 1);
        data_data_ok = 1; data_rdata = 32'h77; expect_resp(1, 32'h77);
        @(negedge clk);
        data_data_ok = 0;

        // Misaligned word load.
        @(negedge clk);
        set_op(0, 2'b10, 0, 32'h1001, 0); data_addr_ok = 0;
        #1;
`ifdef MEM_ALIGN_EXC_EN
        check("mis_exc", 32'(op_exc), 4);
        check("mis_req", 32'(data_req), 0);
        check("mis_ready", 32'(op_ready), 1);
`else
        check("mis_addr", data_addr, 32'h1000);
        check("mis_exc", 32'(op_exc), 0);
        check("mis_req", 32'(data_req), 1);
`endif

        // Killed op: consumed without bus access.
        @(negedge clk);
        set_op(0, 2'b10, 0, 32'h600, 0); op_kill = 1; data_addr_ok = 1;
        #1;
        check("kill_ready", 32'(op_ready), 1);
        check("kill_req", 32'(data_req), 0);
        @(negedge clk);
        op_valid = 0; op_kill = 0; data_addr_ok = 0;
        check("kill_pending", 32'(pending), 0);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        set_op(0, 2'b10, 0, 32'h700, 0); data_addr_ok = 1;
        @(negedge clk);
        op_valid = 0; data_addr_ok = 0;
        check("rst_mid_pending_before", 32'(pending), 1);
        rst = 1;
        #1;
        check("rst_mid_pending", 32'(pending), 0);
        check("rst_mid_resp_data", resp_data, 0);
        @(negedge clk);
        rst = 0;

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Pipelined memory-access unit for the MEM stage: it issues loads and stores on the SRAM-like data bus with up to `MAX_OUTSTANDING` transactions in flight. It keeps per-request metadata in order, so each returned word can be aligned and sign/zero-extended. It replaces the single-outstanding MEM data path, adds flush-with-drain, and sits between the EX/MEM register and the MEM/WB register.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 2: maximum accepted-but-unanswered bus requests (power of two, ≥1).
- `CNT_W`, default `$clog2(MAX_OUTSTANDING+1)`: width of `pending`.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `op_valid` in 1: a memory op is presented this cycle.
- `op_ready` out 1: the op is consumed this cycle.
- `op_wr` in 1: 1 = store, 0 = load.
- `op_size` in 2: 00 byte, 01 half, 10 word.
- `op_signed` in 1: sign-extend the load result.
- `op_kill` in 1: the op carries an upstream exception; consume it without bus access.
- `op_addr` in 32: byte address.
- `op_wdata` in 32: store data, right-aligned.
- `op_exc` out 4: alignment exception code for the presented op (0 = none).
- `flush` in 1: discard all pending results.
- `resp_valid` out 1: the in-order response is valid.
- `resp_is_load` out 1: the response belongs to a load.
- `resp_data` out 32: aligned and extended load data (0 for stores).
- `data_req`, `data_wr`, `data_size`[2], `data_addr`[32], `data_wdata`[32] out: bus request.
- `data_rdata`[32], `data_addr_ok`, `data_data_ok` in: bus response.
- `pending` out `CNT_W`: in-flight count.
- `stall` out 1: `op_valid & ~op_ready`.

## Operation
- Issue condition: `op_valid & ~op_kill & (op_exc==0) & (pending < MAX_OUTSTANDING) & ~draining`.
- Bus request fields:
  - `data_req` equals the issue condition.
  - `data_addr` is `op_addr` with bits [1:0] forced to 00 for word accesses.
  - `data_size` equals `op_size`.
  - `data_wdata` lanes are replicated: byte → {4{b}}, half → {2{h}}, word as-is.
- Consume rules:
  - An op with `op_kill` or nonzero `op_exc` is consumed the same cycle (`op_ready`=1) with no bus activity and no response.
  - An issued op is consumed on `data_req & data_addr_ok`, which pushes {wr, size, signed, addr[1:0], discard=0} into the pending FIFO.
- `data_data_ok` pops the oldest entry and produces the response:
  - Loads: `data_rdata` is shifted right by `addr[1:0]`×8, then extended per size/signed.
  - Stores: `resp_is_load`=0 and `resp_data`=0.
  - Entries marked discard pop silently with `resp_valid`=0.
- Flush:
  - Marks every pending entry discard.
  - Sets `draining` until `pending`==0, which blocks new issues.
  - A flush while `pending`==0 has no effect beyond that cycle.
- Spurious `data_data_ok` with `pending`==0 is ignored and flagged by an assertion.

## Timing
- Reset values: `pending`=0, FIFO empty, `draining`=0, `resp_valid`=0, `resp_data`=0. All bus outputs are combinational from inputs and state, so `data_req`=0 while `op_valid`=0.
- `resp_valid` and `resp_data` are registered: they follow `data_data_ok` by exactly one cycle. Loaded data is also held in a result register until the next response.
- `op_ready` is combinational from `data_addr_ok`, so it is valid in the same cycle.
- Simultaneous `data_addr_ok` and `data_data_ok`: push and pop in the same cycle, `pending` unchanged, FIFO pointers wrap modulo `MAX_OUTSTANDING`.
- `flush` in the same cycle as `data_data_ok`: the popped entry is also discarded. The entry being pushed that cycle is not marked discard.
- A full FIFO blocks issue. A pop in that cycle does not enable issue until the next cycle, so there is no ready-through-pop path.
- Reset asserted mid-operation clears all state immediately. The bus master is reset on the same `rst`.

## Configuration
- `MEM_ALIGN_EXC_EN` defined:
  - A misaligned half or word access sets `op_exc` to 4 (ADEL, load) or 5 (ADES, store).
  - The op is consumed without bus access.
- `MEM_ALIGN_EXC_EN` undefined:
  - `op_exc` is tied to 0.
  - Low address bits are masked to natural alignment before issue.

## Structure
- Package `mem_pkg` holds:
  - `mem_size_e` (BYTE=2'b00, HALF=2'b01, WORD=2'b10).
  - `EXC_ADEL`=4'd4 and `EXC_ADES`=4'd5.
  - `mem_meta_t`, the pending-entry struct.
- Sub-module `mem_pending_fifo`: parametrised-depth FIFO of `mem_meta_t` with push, pop, count and a mark-all-discard input.

## Test plan
- Load byte, signed: addr 0x1003, rdata 0x80FF_FF7F → `resp_data`=0xFFFF_FF80 one cycle after `data_data_ok`.
- Store half: addr 0x2002, wdata 0x0000_BEEF → `data_wdata`=0xBEEF_BEEF, `data_size`=01, `data_addr`=0x2002.
- Back-to-back loads with `MAX_OUTSTANDING`=2 and delayed `data_data_ok`:
  - The third op stalls until the first response.
  - Responses return in order 0x11, 0x22.
- Push and pop in the same cycle: `pending` stays at 1. With `MAX_OUTSTANDING`=2, the pointers wrap correctly over 10 consecutive ops.
- Flush with 2 loads pending:
  - Both `data_data_ok` events produce `resp_valid`=0.
  - A new op waits until `pending`=0.
- Misaligned word load, addr 0x1001:
  - With `MEM_ALIGN_EXC_EN`: `op_exc`=4, `data_req`=0, `op_ready`=1.
  - Without it: `data_addr`=0x1000.
